// File: rtl/ber_mode_sequencer.sv
// BER mode sweep sequencer: steps MAIN_MODE, gates CLR around a dwell window, streams 17-byte count records.
// Optional build macro BER_SEQ_LOOP_EN repeats the sweep until ABORT.
module ber_mode_sequencer #(
    parameter int unsigned DWELL_W    = 32,
    parameter int unsigned SETTLE     = 16,
    parameter int unsigned FIRST_MODE = 9,
    parameter int unsigned LAST_MODE  = 31
) (
    input  logic               CLK,
    input  logic               RSTX,
    input  logic               START,
    input  logic               ABORT,
    input  logic [DWELL_W-1:0] DWELL,
    input  logic [7:0]         SUB_CFG,
    output logic [7:0]         MAIN_MODE,
    output logic [7:0]         SUB_MODE,
    output logic               CLR,
    input  logic [57:0]        RECV_CNT,
    input  logic [63:0]        ERR_CNT,
    output logic [7:0]         TX_DATA,
    output logic               TX_VALID,
    input  logic               TX_READY,
    output logic               BUSY,
    output logic               DONE
);
    localparam int unsigned REC_W     = 136;
    localparam int unsigned REC_BYTES = 17;
    localparam int unsigned IDX_W     = 5;
    localparam int unsigned SET_W     = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [SET_W-1:0] SETTLE_M1  = SET_W'(SETTLE - 1);
    localparam logic [7:0]       FIRST_M    = 8'(FIRST_MODE);
    localparam logic [7:0]       LAST_M     = 8'(LAST_MODE);
    localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(REC_BYTES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_DWELL,
        S_CAPTURE,
        S_SEND,
        S_FINISH
    } state_e;

    state_e             state_q, state_d;
    logic [7:0]         main_mode_q, main_mode_d;
    logic [7:0]         sub_mode_q, sub_mode_d;
    logic               clr_q, clr_d;
    logic [7:0]         tx_data_q, tx_data_d;
    logic               tx_valid_q, tx_valid_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [SET_W-1:0]   settle_cnt_q, settle_cnt_d;
    logic [DWELL_W-1:0] dwell_cnt_q, dwell_cnt_d;
    logic [DWELL_W-1:0] dwell_m1_q, dwell_m1_d;
    logic [REC_W-1:0]   rec_q, rec_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               tx_fire;

    assign tx_fire = tx_valid_q && TX_READY;

    // Next-state and registered-output computation; outputs follow the next state.
    always_comb begin
        state_d      = state_q;
        main_mode_d  = main_mode_q;
        sub_mode_d   = sub_mode_q;
        settle_cnt_d = settle_cnt_q;
        dwell_cnt_d  = dwell_cnt_q;
        dwell_m1_d   = dwell_m1_q;
        rec_d        = rec_q;
        idx_d        = idx_q;
        done_d       = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                main_mode_d = 8'h00;
                sub_mode_d  = 8'h00;
                if (START) begin
                    dwell_m1_d   = (DWELL == '0) ? '0 : DWELL - DWELL_W'(1);
                    sub_mode_d   = SUB_CFG;
                    main_mode_d  = FIRST_M;
                    settle_cnt_d = SETTLE_M1;
                    state_d      = S_CLEAR;
                end
            end
            S_CLEAR: begin
                if (settle_cnt_q == '0) begin
                    dwell_cnt_d = dwell_m1_q;
                    state_d     = S_DWELL;
                end else begin
                    settle_cnt_d = settle_cnt_q - SET_W'(1);
                end
            end
            S_DWELL: begin
                if (dwell_cnt_q == '0) begin
                    state_d = S_CAPTURE;
                end else begin
                    dwell_cnt_d = dwell_cnt_q - DWELL_W'(1);
                end
            end
            S_CAPTURE: begin
                rec_d   = {main_mode_q, 6'b0, RECV_CNT, ERR_CNT};
                idx_d   = '0;
                state_d = S_SEND;
            end
            S_SEND: begin
                // Record is a shift register: the outgoing byte is always the top byte.
                if (tx_fire) begin
                    rec_d = {rec_q[REC_W-9:0], 8'h00};
                    idx_d = idx_q + IDX_W'(1);
                    if (idx_q == LAST_IDX) begin
                        if (main_mode_q == LAST_M) begin
                            done_d = 1'b1;
`ifdef BER_SEQ_LOOP_EN
                            main_mode_d  = FIRST_M;
                            settle_cnt_d = SETTLE_M1;
                            state_d      = S_CLEAR;
`else
                            state_d      = S_FINISH;
`endif
                        end else begin
                            main_mode_d  = main_mode_q + 8'd1;
                            settle_cnt_d = SETTLE_M1;
                            state_d      = S_CLEAR;
                        end
                    end
                end
            end
            S_FINISH: begin
                main_mode_d = 8'h00;
                sub_mode_d  = 8'h00;
                state_d     = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort wins over everything, including a START in the same cycle.
        if (ABORT) begin
            state_d     = S_IDLE;
            main_mode_d = 8'h00;
            sub_mode_d  = 8'h00;
            idx_d       = '0;
            done_d      = 1'b0;
        end

        clr_d      = (state_d != S_DWELL);
        busy_d     = (state_d != S_IDLE);
        tx_valid_d = (state_d == S_SEND);
        tx_data_d  = tx_valid_d ? rec_d[REC_W-1 -: 8] : 8'h00;
    end

    always_ff @(posedge CLK or negedge RSTX) begin
        if (!RSTX) begin
            state_q      <= S_IDLE;
            main_mode_q  <= 8'h00;
            sub_mode_q   <= 8'h00;
            clr_q        <= 1'b1;
            tx_data_q    <= 8'h00;
            tx_valid_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            settle_cnt_q <= '0;
            dwell_cnt_q  <= '0;
            dwell_m1_q   <= '0;
            rec_q        <= '0;
            idx_q        <= '0;
        end else begin
            state_q      <= state_d;
            main_mode_q  <= main_mode_d;
            sub_mode_q   <= sub_mode_d;
            clr_q        <= clr_d;
            tx_data_q    <= tx_data_d;
            tx_valid_q   <= tx_valid_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            settle_cnt_q <= settle_cnt_d;
            dwell_cnt_q  <= dwell_cnt_d;
            dwell_m1_q   <= dwell_m1_d;
            rec_q        <= rec_d;
            idx_q        <= idx_d;
        end
    end

    assign MAIN_MODE = main_mode_q;
    assign SUB_MODE  = sub_mode_q;
    assign CLR       = clr_q;
    assign TX_DATA   = tx_data_q;
    assign TX_VALID  = tx_valid_q;
    assign BUSY      = busy_q;
    assign DONE      = done_q;

endmodule

// File: tb/tb_ber_mode_sequencer.sv
// Directed bench for ber_mode_sequencer: single-mode and three-mode instances, record contents,
// CLR timing, back-pressure, abort and async reset. Honours BER_SEQ_LOOP_EN when defined.
`timescale 1ns/1ps
module tb_ber_mode_sequencer;
    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstx, start_a, start_b, abort, tx_ready, use_b;
    logic [31:0] dwell;
    logic [7:0]  sub_cfg;
    logic [57:0] recv;
    logic [63:0] err;

    logic [7:0] main_a, sub_a, txd_a, main_b, sub_b, txd_b;
    logic       clr_a, txv_a, busy_a, done_a, clr_b, txv_b, busy_b, done_b;
    logic [7:0] obs_main, obs_sub, obs_data;
    logic       obs_clr, obs_valid, obs_busy, obs_done;

    int checks = 0;
    int errors = 0;
    logic [7:0] rxq[$];
    int clr_high, clr_low, done_cnt, done_at;

    ber_mode_sequencer #(.DWELL_W(32), .SETTLE(16), .FIRST_MODE(9), .LAST_MODE(9)) u_dut_a (
        .CLK(clk), .RSTX(rstx), .START(start_a), .ABORT(abort), .DWELL(dwell), .SUB_CFG(sub_cfg),
        .MAIN_MODE(main_a), .SUB_MODE(sub_a), .CLR(clr_a), .RECV_CNT(recv), .ERR_CNT(err),
        .TX_DATA(txd_a), .TX_VALID(txv_a), .TX_READY(tx_ready), .BUSY(busy_a), .DONE(done_a));

    ber_mode_sequencer #(.DWELL_W(32), .SETTLE(16), .FIRST_MODE(9), .LAST_MODE(11)) u_dut_b (
        .CLK(clk), .RSTX(rstx), .START(start_b), .ABORT(abort), .DWELL(dwell), .SUB_CFG(sub_cfg),
        .MAIN_MODE(main_b), .SUB_MODE(sub_b), .CLR(clr_b), .RECV_CNT(recv), .ERR_CNT(err),
        .TX_DATA(txd_b), .TX_VALID(txv_b), .TX_READY(tx_ready), .BUSY(busy_b), .DONE(done_b));

    always_comb begin
        obs_main  = use_b ? main_b : main_a;
        obs_sub   = use_b ? sub_b  : sub_a;
        obs_data  = use_b ? txd_b  : txd_a;
        obs_clr   = use_b ? clr_b  : clr_a;
        obs_valid = use_b ? txv_b  : txv_a;
        obs_busy  = use_b ? busy_b : busy_a;
        obs_done  = use_b ? done_b : done_a;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] exp_byte(input logic [7:0] mode, input logic [57:0] r,
                                            input logic [63:0] e, input int i);
        logic [135:0] rec;
        rec = {mode, 6'b0, r, e};
        return rec[135 - 8*i -: 8];
    endfunction

    task automatic chk_record(input string tag, input int base, input logic [7:0] mode);
        for (int i = 0; i < 17; i++) begin
            if (base + i < rxq.size())
                chk($sformatf("%s_byte%0d", tag, i), 64'(rxq[base + i]), 64'(exp_byte(mode, recv, err, i)));
        end
    endtask

    task automatic chk_outputs_idle(input string tag);
        chk({tag, "_busy"},  64'(obs_busy),  64'(1'b0));
        chk({tag, "_clr"},   64'(obs_clr),   64'(1'b1));
        chk({tag, "_main"},  64'(obs_main),  64'(8'h00));
        chk({tag, "_valid"}, 64'(obs_valid), 64'(1'b0));
        chk({tag, "_done"},  64'(obs_done),  64'(1'b0));
    endtask

    // Runs one sweep: collects handshaken bytes, CLR timing, stall stability; ends on DONE, idle or abort.
    task automatic sweep(input bit toggle, input int abort_at, input int poke_at, input int budget);
        bit started_low = 1'b0, pv = 1'b0, pr = 1'b0, armed = 1'b0;
        logic [7:0] pd = 8'h00;
        rxq.delete();
        clr_high = 0; clr_low = 0; done_cnt = 0; done_at = -1;
        for (int cyc = 0; cyc < budget; cyc++) begin
            tick();
            start_a = 1'b0;
            start_b = 1'b0;
            if (armed) begin
                abort = 1'b0;
                chk_outputs_idle("abort");
                chk("abort_sub", 64'(obs_sub), 64'(8'h00));
                return;
            end
            if (pv && !pr) begin
                chk("stall_valid", 64'(obs_valid), 64'(1'b1));
                chk("stall_data", 64'(obs_data), 64'(pd));
            end
            if (obs_done) begin
                done_cnt++;
                done_at = rxq.size();
                return;
            end
            if (!obs_busy) return;
            if (!obs_clr) begin
                clr_low++;
                started_low = 1'b1;
            end else if (!started_low) begin
                clr_high++;
            end
            if (cyc == poke_at) begin
                if (use_b) start_b = 1'b1; else start_a = 1'b1;
                dwell   = 32'd50;
                sub_cfg = 8'hFF;
            end
            tx_ready = toggle ? ((cyc % 2) == 1) : 1'b1;
            if (abort_at >= 0 && obs_valid && rxq.size() == abort_at) begin
                abort = 1'b1;
                armed = 1'b1;
            end else if (obs_valid && tx_ready) begin
                rxq.push_back(obs_data);
            end
            pv = obs_valid; pr = tx_ready; pd = obs_data;
        end
        chk("sweep_timeout_busy", 64'(obs_busy), 64'(1'b0));
    endtask

    task automatic end_sweep(input string tag);
`ifdef BER_SEQ_LOOP_EN
        chk({tag, "_reload_busy"}, 64'(obs_busy), 64'(1'b1));
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk_outputs_idle({tag, "_loop_abort"});
`else
        tick();
        chk_outputs_idle({tag, "_end"});
        chk({tag, "_end_sub"}, 64'(obs_sub), 64'(8'h00));
`endif
        tx_ready = 1'b1;
    endtask

    initial begin
        rstx = 1'b0; start_a = 1'b0; start_b = 1'b0; abort = 1'b0; tx_ready = 1'b0; use_b = 1'b0;
        dwell = 32'd0; sub_cfg = 8'h00; recv = '0; err = '0;
        repeat (3) tick();
        chk_outputs_idle("rst_a");
        chk("rst_a_data", 64'(txd_a), 64'(8'h00));
        chk("rst_a_sub", 64'(sub_a), 64'(8'h00));
        chk("rst_b_busy", 64'(busy_b), 64'(1'b0));
        chk("rst_b_clr", 64'(clr_b), 64'(1'b1));
        rstx = 1'b1;
        tick();

        // Single mode, dwell 100, free-flowing sink.
        dwell = 32'd100; sub_cfg = 8'hA5; recv = 58'h1234; err = 64'h5; start_a = 1'b1;
        sweep(1'b0, -1, -1, 2000);
        chk("t2_clr_high", 64'(clr_high), 64'd16);
        chk("t2_clr_low", 64'(clr_low), 64'd100);
        chk("t2_nbytes", 64'(rxq.size()), 64'd17);
        chk("t2_done_cnt", 64'(done_cnt), 64'd1);
        chk("t2_done_at", 64'(done_at), 64'd17);
        chk("t2_sub", 64'(obs_sub), 64'(8'hA5));
        chk("t2_main_at_done", 64'(obs_main), 64'(8'h09));
        if (rxq.size() == 17) begin
            chk("t2_b0", 64'(rxq[0]), 64'(8'h09));
            chk("t2_b1", 64'(rxq[1]), 64'(8'h00));
            chk("t2_b7", 64'(rxq[7]), 64'(8'h12));
            chk("t2_b8", 64'(rxq[8]), 64'(8'h34));
            chk("t2_b15", 64'(rxq[15]), 64'(8'h00));
            chk("t2_b16", 64'(rxq[16]), 64'(8'h05));
        end
        end_sweep("t2");

        // Back-pressure: ready toggles every cycle.
        dwell = 32'd5; recv = 58'h123_4567_89AB_CDEF; err = 64'hFEDC_BA98_7654_3210; start_a = 1'b1;
        sweep(1'b1, -1, -1, 2000);
        chk("t3_clr_low", 64'(clr_low), 64'd5);
        chk("t3_nbytes", 64'(rxq.size()), 64'd17);
        chk("t3_done_cnt", 64'(done_cnt), 64'd1);
        chk_record("t3", 0, 8'h09);
        end_sweep("t3");

        // Three modes, DWELL=0 acts as 1, START re-pulsed mid-sweep must be ignored.
        use_b = 1'b1; dwell = 32'd0; sub_cfg = 8'h3C; recv = 58'h2_0000_0000_00AB; err = 64'h0102_0304_0506_0708;
        start_b = 1'b1;
        sweep(1'b0, -1, 40, 3000);
        chk("t4_clr_high", 64'(clr_high), 64'd16);
        chk("t4_clr_low", 64'(clr_low), 64'd3);
        chk("t4_nbytes", 64'(rxq.size()), 64'd51);
        chk("t4_done_cnt", 64'(done_cnt), 64'd1);
        chk("t4_done_at", 64'(done_at), 64'd51);
        chk("t4_sub", 64'(obs_sub), 64'(8'h3C));
`ifdef BER_SEQ_LOOP_EN
        chk("t4_main_reload", 64'(obs_main), 64'(8'h09));
`else
        chk("t4_main_at_done", 64'(obs_main), 64'(8'h0B));
`endif
        chk_record("t4_m9", 0, 8'h09);
        chk_record("t4_m10", 17, 8'h0A);
        chk_record("t4_m11", 34, 8'h0B);
        end_sweep("t4");
        use_b = 1'b0;

        // Abort while byte 5 is on the wire, then a clean restart.
        dwell = 32'd3; recv = 58'h3FF; err = 64'hDEAD_BEEF_0000_0001; start_a = 1'b1;
        sweep(1'b0, 5, -1, 2000);
        chk("t5_nbytes", 64'(rxq.size()), 64'd5);
        chk("t5_done_cnt", 64'(done_cnt), 64'd0);
        tick();
        chk("t5_still_idle", 64'(obs_busy), 64'(1'b0));
        start_a = 1'b1;
        sweep(1'b0, -1, -1, 2000);
        chk("t5_re_nbytes", 64'(rxq.size()), 64'd17);
        chk("t5_re_done", 64'(done_cnt), 64'd1);
        chk_record("t5_re", 0, 8'h09);
        end_sweep("t5");

        // START and ABORT together in IDLE: stay idle.
        start_a = 1'b1; abort = 1'b1;
        tick();
        start_a = 1'b0; abort = 1'b0;
        chk_outputs_idle("sa_abort");
        tick();
        chk("sa_abort_busy2", 64'(obs_busy), 64'(1'b0));

        // Asynchronous reset in the middle of the dwell window.
        dwell = 32'd100; sub_cfg = 8'h77; start_a = 1'b1;
        tick();
        start_a = 1'b0;
        repeat (29) tick();
        chk("t1_pre_busy", 64'(obs_busy), 64'(1'b1));
        chk("t1_pre_clr", 64'(obs_clr), 64'(1'b0));
        chk("t1_pre_main", 64'(obs_main), 64'(8'h09));
        #2;
        rstx = 1'b0;
        #1;
        chk_outputs_idle("t1_async");
        chk("t1_async_sub", 64'(obs_sub), 64'(8'h00));
        chk("t1_async_data", 64'(obs_data), 64'(8'h00));
        tick();
        rstx = 1'b1;
        tick();
        chk("t1_post_busy", 64'(obs_busy), 64'(1'b0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
